mem_req_ctrl: RTL and testbench

Request controller that sits directly upstream of the 32x8 ack-handshake memory. It buffers read/write commands in a small FIFO and drives the memory's `read`/`write`/`addr`/`data_i` strobes one transaction at a time, holding each strobe until `ack`. It returns one response per command, either read data or an error, and can optionally abort a transaction the memory never acknowledges.

---
 rtl/mem_req_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: command FIFO feeding a single-outstanding ack-handshake
// memory master. One response per command (read data, or error on timeout).
// Optional feature: define MEM_REQ_CTRL_TIMEOUT_EN to abort a transaction
// after TIMEOUT sampled edges without ack; otherwise REQ waits indefinitely.
`timescale 1ns/1ps
module mem_req_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] data_o,
  input  logic              ack
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam bit CFG_OK = (FIFO_DEPTH >= 2) &&
                          ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
                          (TIMEOUT >= 1) && (TIMEOUT <= 255);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("mem_req_ctrl: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT in 1..255");
    end
  endgenerate

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data  [FIFO_DEPTH];
  logic              fifo_write [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [0:0]       state;
  logic             cur_write;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == ST_IDLE) && !empty;
  assign busy      = !empty || (state != ST_IDLE);

  // FIFO storage; read data is zeroed at entry so data_i never shows stale write data for reads
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_data[wr_ptr]  <= cmd_write ? cmd_wdata : '0;
      fifo_write[wr_ptr] <= cmd_write;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

`ifdef MEM_REQ_CTRL_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  // Transaction FSM: issue one strobe, hold until ack (or timeout), emit response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      read      <= 1'b0;
      write     <= 1'b0;
      addr      <= '0;
      data_i    <= '0;
      cur_write <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            addr      <= fifo_addr[rd_ptr];
            data_i    <= fifo_data[rd_ptr];
            write     <= fifo_write[rd_ptr];
            read      <= !fifo_write[rd_ptr];
            cur_write <= fifo_write[rd_ptr];
            state     <= ST_REQ;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        default: begin
          if (ack) begin
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= cur_write;
            rsp_rdata <= cur_write ? '0 : data_o;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= ST_IDLE;
          end
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
          // Counter holds edges already waited, so the TIMEOUT-th ack-less edge aborts
          else if (wait_cnt == WAIT_LAST) begin
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= cur_write;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt  <= wait_cnt + 8'd1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: table of single transactions plus hand-written
// sequences for latency, FIFO full, timeout, ack-at-limit and mid-run reset.
`timescale 1ns/1ps
module tb_mem_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       ack;

  int total = 0;
  int bad = 0;

  mem_req_ctrl #(.ADDR_W(5), .DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .read(read), .write(write), .addr(addr), .data_i(data_i),
    .data_o(data_o), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory model: acks ack_delay edges after seeing a strobe, unless hold_ack
  logic [7:0] mem [32];
  int  ack_delay = 0;
  bit  hold_ack = 1'b0;
  int  mwait = 0;

  initial begin
    ack = 1'b0;
    data_o = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (ack) begin
        ack = 1'b0;
      end else if ((read || write) && !hold_ack) begin
        if (mwait >= ack_delay) begin
          if (write) mem[addr] = data_i;
          data_o = mem[addr];
          ack = 1'b1;
          mwait = 0;
        end else begin
          mwait++;
        end
      end else begin
        mwait = 0;
      end
    end
  end

  typedef struct { bit w; logic [7:0] rd; bit err; } rsp_t;
  rsp_t rsp_q[$];

  // Response monitor; strobes must already be low in the response cycle
  initial begin
    forever begin
      @(negedge clk);
      if (read || write) chk("strobe_exclusive", {31'd0, read & write}, 32'd0);
      if (rsp_valid) begin
        rsp_t r;
        r.w = rsp_write;
        r.rd = rsp_rdata;
        r.err = rsp_err;
        rsp_q.push_back(r);
        chk("strobe_gap", {30'd0, read, write}, 32'd0);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic send_cmd(bit w, logic [4:0] a, logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL send_cmd: cmd_ready stuck at 0 (required 1)");
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(string name, bit exp_w, logic [7:0] exp_rd, bit exp_err);
    int n = 0;
    rsp_t r;
    while (rsp_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no response within 100 cycles", name);
      return;
    end
    r = rsp_q.pop_front();
    chk({name, "_write"}, {31'd0, r.w}, {31'd0, exp_w});
    chk({name, "_rdata"}, {24'd0, r.rd}, {24'd0, exp_rd});
    chk({name, "_err"}, {31'd0, r.err}, {31'd0, exp_err});
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_write"}, {31'd0, rsp_write}, 32'd0);
    chk({tag, "_rsp_rdata"}, {24'd0, rsp_rdata}, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_read"}, {31'd0, read}, 32'd0);
    chk({tag, "_write"}, {31'd0, write}, 32'd0);
    chk({tag, "_addr"}, {27'd0, addr}, 32'd0);
    chk({tag, "_data_i"}, {24'd0, data_i}, 32'd0);
  endtask

  typedef struct {
    bit         w;
    logic [4:0] a;
    logic [7:0] d;
    int         delay;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{w: 1'b1, a: 5'd0,      d: 8'h00, delay: 0, exp_rd: 8'h00};
    vecs[1] = '{w: 1'b0, a: 5'd0,      d: 8'h00, delay: 0, exp_rd: 8'h00};
    vecs[2] = '{w: 1'b1, a: 5'd31,     d: 8'hA5, delay: 1, exp_rd: 8'h00};
    vecs[3] = '{w: 1'b0, a: 5'd31,     d: 8'h00, delay: 1, exp_rd: 8'hA5};
    vecs[4] = '{w: 1'b1, a: 5'b10101,  d: 8'hFF, delay: 2, exp_rd: 8'h00};
    vecs[5] = '{w: 1'b0, a: 5'b10101,  d: 8'h00, delay: 2, exp_rd: 8'hFF};

    // Power-on reset
    #1;
    check_reset_vals("por");
    #13;
    rst_n = 1'b1;

    // Latency: accepted at N, strobe after N+1, response after N+2
    ack_delay = 0;
    send_cmd(1'b1, 5'd3, 8'h5A);
    chk("lat_n_write", {31'd0, write}, 32'd0);
    chk("lat_n_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("lat_n1_write", {31'd0, write}, 32'd1);
    chk("lat_n1_addr", {27'd0, addr}, 32'd3);
    chk("lat_n1_data_i", {24'd0, data_i}, 32'h5A);
    @(posedge clk); #1;
    chk("lat_n2_write", {31'd0, write}, 32'd0);
    chk("lat_n2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("lat_n3_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_n3_busy", {31'd0, busy}, 32'd0);
    get_rsp("lat", 1'b1, 8'h00, 1'b0);

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      ack_delay = vecs[i].delay;
      send_cmd(vecs[i].w, vecs[i].a, vecs[i].d);
      get_rsp($sformatf("vec%0d", i), vecs[i].w, vecs[i].w ? 8'h00 : vecs[i].exp_rd, 1'b0);
    end

    // Short asynchronous reset pulse mid-cycle
    @(posedge clk); #3;
    rst_n = 1'b0;
    #0.5;
    check_reset_vals("pulse");
    #0.5;
    rst_n = 1'b1;

    // Fill the FIFO behind a stalled read
    ack_delay = 0;
    hold_ack = 1'b1;
    send_cmd(1'b0, 5'd2, 8'h00);
    send_cmd(1'b1, 5'd2, 8'h11);
    send_cmd(1'b1, 5'd3, 8'h22);
    send_cmd(1'b1, 5'd4, 8'h33);
    send_cmd(1'b1, 5'd5, 8'h44);
    chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    hold_ack = 1'b0;
    begin
      int n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!rsp_valid && n < 10);
    end
    chk("full_ack_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("full_ack_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("full_pop_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("full_pop_write", {31'd0, write}, 32'd1);
    chk("full_pop_addr", {27'd0, addr}, 32'd2);
    chk("full_pop_data_i", {24'd0, data_i}, 32'h11);
    get_rsp("full_blk", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) get_rsp($sformatf("full_wr%0d", i), 1'b1, 8'h00, 1'b0);
    begin
      logic [7:0] exp_d [4];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
      for (int i = 0; i < 4; i++) send_cmd(1'b0, 5'(i + 2), 8'h00);
      for (int i = 0; i < 4; i++) get_rsp($sformatf("full_rd%0d", i), 1'b0, exp_d[i], 1'b0);
    end

`ifdef MEM_REQ_CTRL_TIMEOUT_EN
    // Read never acknowledged: aborts on the 20th edge in REQ, next command proceeds
    hold_ack = 1'b1;
    send_cmd(1'b0, 5'd7, 8'h00);
    send_cmd(1'b1, 5'd8, 8'h77);
    chk("to_p_read", {31'd0, read}, 32'd1);
    repeat (19) @(posedge clk);
    #1;
    chk("to_19_read", {31'd0, read}, 32'd1);
    chk("to_19_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("to_20_read", {31'd0, read}, 32'd0);
    chk("to_20_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_20_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_20_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    @(negedge clk);
    hold_ack = 1'b0;
    @(posedge clk); #1;
    chk("to_next_write", {31'd0, write}, 32'd1);
    chk("to_next_addr", {27'd0, addr}, 32'd8);
    get_rsp("to_err", 1'b0, 8'h00, 1'b1);
    get_rsp("to_next", 1'b1, 8'h00, 1'b0);
`else
    ack_delay = 0;
    send_cmd(1'b1, 5'd8, 8'h77);
    get_rsp("wr8", 1'b1, 8'h00, 1'b0);
`endif

    // Ack arriving on the 20th edge in REQ gives a normal response
    ack_delay = 19;
    send_cmd(1'b0, 5'd8, 8'h00);
    @(posedge clk); #1;
    chk("ack20_p_read", {31'd0, read}, 32'd1);
    repeat (19) @(posedge clk);
    #1;
    chk("ack20_19_read", {31'd0, read}, 32'd1);
    @(posedge clk); #1;
    chk("ack20_read", {31'd0, read}, 32'd0);
    chk("ack20_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ack20_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("ack20_rsp_rdata", {24'd0, rsp_rdata}, 32'h77);
    get_rsp("ack20", 1'b0, 8'h77, 1'b0);

    // Reset during REQ with two commands queued
    ack_delay = 0;
    hold_ack = 1'b1;
    send_cmd(1'b0, 5'd2, 8'h00);
    send_cmd(1'b0, 5'd3, 8'h00);
    send_cmd(1'b0, 5'd4, 8'h00);
    chk("mr_read_before", {31'd0, read}, 32'd1);
    chk("mr_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #0.5;
    chk("mr_read_in_reset", {31'd0, read}, 32'd0);
    chk("mr_write_in_reset", {31'd0, write}, 32'd0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    hold_ack = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mr_no_rsp", rsp_q.size(), 32'd0);
    chk("mr_busy_after", {31'd0, busy}, 32'd0);
    chk("mr_read_after", {31'd0, read}, 32'd0);
    chk("mr_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
